// File: rtl/maxpool2d_stream_if.sv
// Pixel-in / pooled-pixel-out stream bundle for maxpool2d_stream.
// The master is the upstream feeder; it also owns the frame-restart strobe.
interface maxpool2d_stream_if #(
    parameter int DATA_W = 16,
    parameter int CH     = 4
);
    logic                 clr;
    logic                 pix_valid;
    logic [CH*DATA_W-1:0] pix_data;
    logic                 pool_valid;
    logic [CH*DATA_W-1:0] pool_data;
    logic                 pool_last;

    modport master (
        output clr, pix_valid, pix_data,
        input  pool_valid, pool_data, pool_last
    );

    modport slave (
        input  clr, pix_valid, pix_data,
        output pool_valid, pool_data, pool_last
    );
endinterface

// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 stride-2 signed max-pooling over a raster feature map with CH packed channels.
// One horizontal hold register plus a half-width line buffer; pooled pixel registered once.
module maxpool2d_stream #(
    parameter int DATA_W = 16,
    parameter int CH     = 4,
    parameter int IMG_W  = 112,
    parameter int IMG_H  = 112
) (
    input  logic               clk,
    input  logic               rst,
    maxpool2d_stream_if.slave  bus
);
    localparam int PIX_W = CH * DATA_W;
    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_D  = IMG_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    // Per-channel signed maximum; ties return either operand since they are equal.
    function automatic logic [PIX_W-1:0] pix_max(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        logic signed [DATA_W-1:0] ca;
        logic signed [DATA_W-1:0] cb;
        logic        [PIX_W-1:0]  r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            ca = a[k*DATA_W +: DATA_W];
            cb = b[k*DATA_W +: DATA_W];
            r[k*DATA_W +: DATA_W] = (ca >= cb) ? ca : cb;
        end
        return r;
    endfunction

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             win_done;
    logic [LB_AW-1:0] lb_addr;
    logic [PIX_W-1:0] hmax;

    logic [PIX_W-1:0] hold_p0;
    logic [PIX_W-1:0] lb_rd_p0;
    logic [PIX_W-1:0] lb [LB_D];

    logic             vld_p1;
    logic             last_p1;
    logic [PIX_W-1:0] data_p1;

    always_comb begin
        accept   = bus.pix_valid & ~bus.clr;
        col_last = (col == COL_W'(IMG_W - 1));
        row_last = (row == ROW_W'(IMG_H - 1));
        win_done = accept & col[0] & row[0];
        lb_addr  = LB_AW'(col >> 1);
        hmax     = pix_max(hold_p0, bus.pix_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (bus.clr) begin
            col     <= '0;
            row     <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= win_done;
            last_p1 <= accept & col_last & row_last;
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // Stage p0: horizontal hold, line-buffer write on even rows, prefetch on odd rows.
    // The prefetch at the even column lines up the read with the odd-column beat that uses it.
    always_ff @(posedge clk) begin
        if (accept && !col[0])
            hold_p0 <= bus.pix_data;
        if (accept && col[0] && !row[0])
            lb[lb_addr] <= hmax;
        if (accept && !col[0] && row[0])
            lb_rd_p0 <= lb[lb_addr];
    end

    // Stage p1: vertical max registered to the output.
    always_ff @(posedge clk) begin
        if (rst)
            data_p1 <= '0;
        else if (win_done)
            data_p1 <= pix_max(lb_rd_p0, hmax);
    end

    assign bus.pool_valid = vld_p1;
    assign bus.pool_last  = last_p1;
    assign bus.pool_data  = data_p1;
endmodule

// File: tb/tb_maxpool2d_stream.sv
// Directed bench for maxpool2d_stream on 4x4 frames: one CH=1 and one CH=2 instance, DATA_W=8.
module tb_maxpool2d_stream;
    typedef struct {
        logic [15:0] pix;
        logic        exp_vld;
        logic [15:0] exp_data;
        logic        exp_last;
    } vec_t;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    vec_t t_inc [16];
    vec_t t_sgn [16];
    vec_t t_ch2 [16];

    maxpool2d_stream_if #(.DATA_W(8), .CH(1)) b1 ();
    maxpool2d_stream_if #(.DATA_W(8), .CH(2)) b2 ();

    maxpool2d_stream #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(4)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave));
    maxpool2d_stream #(.DATA_W(8), .CH(2), .IMG_W(4), .IMG_H(4)) u2 (
        .clk(clk), .rst(rst), .bus(b2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    // One clock: apply inputs, take the edge, sample 1 time unit later, release inputs.
    task automatic cycle(input bit sel, input logic v, input logic [15:0] d, input logic c);
        if (!sel) begin
            b1.pix_valid = v; b1.pix_data = d[7:0]; b1.clr = c;
        end else begin
            b2.pix_valid = v; b2.pix_data = d;      b2.clr = c;
        end
        @(posedge clk);
        #1;
        b1.pix_valid = 1'b0; b1.clr = 1'b0;
        b2.pix_valid = 1'b0; b2.clr = 1'b0;
    endtask

    task automatic check_out(input bit sel, input logic ev, input logic [15:0] ed,
                             input logic el, input string nm);
        logic        av;
        logic        al;
        logic [15:0] ad;
        if (!sel) begin
            av = b1.pool_valid; al = b1.pool_last; ad = {8'h00, b1.pool_data};
        end else begin
            av = b2.pool_valid; al = b2.pool_last; ad = b2.pool_data;
        end
        chk({nm, "_vld"}, {15'd0, av}, {15'd0, ev});
        chk({nm, "_last"}, {15'd0, al}, {15'd0, el});
        if (ev)
            chk({nm, "_data"}, ad, ed);
    endtask

    task automatic run_table(input bit sel, input int which, input int n, input int gapmax,
                             input string nm);
        vec_t v;
        int   g;
        for (int i = 0; i < n; i++) begin
            v = (which == 0) ? t_inc[i] : (which == 1) ? t_sgn[i] : t_ch2[i];
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            for (int k = 0; k < g; k++) begin
                cycle(sel, 1'b0, 16'hxxxx, 1'b0);
                check_out(sel, 1'b0, 16'h0, 1'b0, {nm, "_gap"});
            end
            cycle(sel, 1'b1, v.pix, 1'b0);
            check_out(sel, v.exp_vld, v.exp_data, v.exp_last, $sformatf("%s_%0d", nm, i));
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;

        // Raster 0..15: windows {0,1,4,5},{2,3,6,7},{8,9,12,13},{10,11,14,15}.
        for (int i = 0; i < 16; i++) begin
            t_inc[i].pix = 16'(i); t_inc[i].exp_vld = 1'b0;
            t_inc[i].exp_data = 16'h0; t_inc[i].exp_last = 1'b0;
        end
        t_inc[5].exp_vld  = 1'b1; t_inc[5].exp_data  = 16'd5;
        t_inc[7].exp_vld  = 1'b1; t_inc[7].exp_data  = 16'd7;
        t_inc[13].exp_vld = 1'b1; t_inc[13].exp_data = 16'd13;
        t_inc[15].exp_vld = 1'b1; t_inc[15].exp_data = 16'd15; t_inc[15].exp_last = 1'b1;

        // Signed frame, raster rows:
        //  -128  -1 -128 -128 / -50 -2 -128 -128 / 127 -128 3 -7 / 0 5 -7 2
        t_sgn[0].pix  = 16'h0080; t_sgn[1].pix  = 16'h00FF;
        t_sgn[2].pix  = 16'h0080; t_sgn[3].pix  = 16'h0080;
        t_sgn[4].pix  = 16'h00CE; t_sgn[5].pix  = 16'h00FE;
        t_sgn[6].pix  = 16'h0080; t_sgn[7].pix  = 16'h0080;
        t_sgn[8].pix  = 16'h007F; t_sgn[9].pix  = 16'h0080;
        t_sgn[10].pix = 16'h0003; t_sgn[11].pix = 16'h00F9;
        t_sgn[12].pix = 16'h0000; t_sgn[13].pix = 16'h0005;
        t_sgn[14].pix = 16'h00F9; t_sgn[15].pix = 16'h0002;
        for (int i = 0; i < 16; i++) begin
            t_sgn[i].exp_vld = 1'b0; t_sgn[i].exp_data = 16'h0; t_sgn[i].exp_last = 1'b0;
        end
        t_sgn[5].exp_vld  = 1'b1; t_sgn[5].exp_data  = 16'h00FF;
        t_sgn[7].exp_vld  = 1'b1; t_sgn[7].exp_data  = 16'h0080;
        t_sgn[13].exp_vld = 1'b1; t_sgn[13].exp_data = 16'h007F;
        t_sgn[15].exp_vld = 1'b1; t_sgn[15].exp_data = 16'h0003; t_sgn[15].exp_last = 1'b1;

        // Two channels: ch0 = i, ch1 = 15 - i (ch1 in the upper byte).
        for (int i = 0; i < 16; i++) begin
            t_ch2[i].pix = {8'(15 - i), 8'(i)}; t_ch2[i].exp_vld = 1'b0;
            t_ch2[i].exp_data = 16'h0; t_ch2[i].exp_last = 1'b0;
        end
        t_ch2[5].exp_vld  = 1'b1; t_ch2[5].exp_data  = 16'h0F05;
        t_ch2[7].exp_vld  = 1'b1; t_ch2[7].exp_data  = 16'h0D07;
        t_ch2[13].exp_vld = 1'b1; t_ch2[13].exp_data = 16'h070D;
        t_ch2[15].exp_vld = 1'b1; t_ch2[15].exp_data = 16'h050F; t_ch2[15].exp_last = 1'b1;

        b1.pix_valid = 1'b0; b1.pix_data = '0; b1.clr = 1'b0;
        b2.pix_valid = 1'b0; b2.pix_data = '0; b2.clr = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_vld1",  {15'd0, b1.pool_valid}, 16'd0);
        chk("rst_last1", {15'd0, b1.pool_last},  16'd0);
        chk("rst_data1", {8'd0, b1.pool_data},   16'd0);
        chk("rst_vld2",  {15'd0, b2.pool_valid}, 16'd0);
        chk("rst_data2", b2.pool_data,           16'd0);

        run_table(1'b0, 0, 16, 0, "inc");
        run_table(1'b0, 1, 16, 0, "sgn");
        run_table(1'b1, 2, 16, 0, "ch2");
        run_table(1'b0, 0, 16, 5, "gap");

        // Two back-to-back frames, then a partial frame cut by a restart.
        run_table(1'b0, 0, 16, 0, "f1");
        run_table(1'b0, 0, 16, 0, "f2");
        run_table(1'b0, 0, 7, 0, "part");
        cycle(1'b0, 1'b1, 16'h00AA, 1'b1);
        check_out(1'b0, 1'b0, 16'h0, 1'b0, "clr");
        chk("clr_hold_data", {8'd0, b1.pool_data}, 16'd5);
        run_table(1'b0, 0, 16, 0, "postclr");

        // Mid-frame reset with a beat presented in the same cycle.
        run_table(1'b0, 0, 3, 0, "prerst");
        b1.pix_valid = 1'b1; b1.pix_data = 8'hFF; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; b1.pix_valid = 1'b0;
        chk("midrst_vld",  {15'd0, b1.pool_valid}, 16'd0);
        chk("midrst_last", {15'd0, b1.pool_last},  16'd0);
        chk("midrst_data", {8'd0, b1.pool_data},   16'd0);
        run_table(1'b0, 0, 16, 0, "postrst");

        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        check_out(1'b0, 1'b0, 16'h0, 1'b0, "tail");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/maxpool2d_stream.md
# maxpool2d_stream

Streaming 2x2, stride-2 max-pooling stage for the radar STFT CNN datapath. It follows a convolution/activation layer and takes a raster-scanned feature map, one pixel per valid beat, with CH channels packed side by side. For each 2x2 window it emits the signed maximum per channel, producing an (IMG_W/2) x (IMG_H/2) map. Unlike the earlier single-bit OR-pooling block, it handles multi-bit signed data, multiple channels, gapped input, frame tracking and a frame-restart control.

## Interface
- DW, 16, bits per channel sample, signed two's complement
- CH, 4, channels packed in one beat
- IMG_W, 112, input columns per row; must be even, >= 2
- IMG_H, 112, input rows per frame; must be even, >= 2
- iCLK  in  1  clock, all logic on rising edge
- iRST  in  1  reset, synchronous, active-high
- iCLR  in  1  synchronous frame restart: discards the partial frame and zeroes counters
- iVALID  in  1  iDATA holds a valid pixel this cycle
- iDATA  in  CH*DW  pixel; channel k at bits [k*DW +: DW]
- oVALID  out  1  oDATA holds one pooled pixel, one-cycle pulse
- oDATA  out  CH*DW  pooled pixel, same packing as iDATA
- oLAST  out  1  high with oVALID on the final pooled pixel of a frame

## Operation
- Counters:
  - col counts 0..IMG_W-1 and advances on each accepted beat (iVALID=1, iCLR=0).
  - row counts 0..IMG_H-1 and advances when col wraps.
  - Both wrap to 0 after pixel (IMG_H-1, IMG_W-1). The next frame follows with no gap or idle cycle required.
- Horizontal stage: on even col, register the pixel per channel (hold reg). On odd col, hmax = signed max(hold, pixel) per channel.
- Even row, odd col: write hmax to line buffer entry col>>1. Depth is IMG_W/2, width is CH*DW. No output.
- Odd row, odd col: vmax = signed max(linebuf[col>>1], hmax) per channel, registered to oDATA with oVALID=1.
  - oLAST=1 iff row=IMG_H-1 and col=IMG_W-1.
- Odd row, even col: no output.
- Comparison is a signed DW-bit compare. On a tie either operand may be chosen, since the values are equal. Channels are fully independent.
- The line buffer and hold reg are not reset. Every read is preceded by a write in the same frame, so stale contents are never observed.
- No backpressure. The downstream stage must accept oVALID every cycle it occurs.
- Priority order: iRST > iCLR > iVALID.
  - When iCLR=1, any beat presented that cycle is dropped.
  - col and row go to 0, and oVALID is forced to 0 the next cycle.
  - A pooled result already registered (oVALID=1 in the iCLR cycle) is still presented that cycle.

## Timing
- Reset values: oVALID=0, oDATA=0, oLAST=0, col=0, row=0.
- Latency: oVALID rises on the rising edge after the beat that completes a window (odd row, odd col), i.e. 1 cycle.
- oDATA holds its last value when oVALID=0. Downstream must qualify with oVALID.
- Input may be gapped arbitrarily (iVALID low for any number of cycles). The state holds across gaps. Back-to-back beats give at most one output per 2 input beats.
- Output count per frame is exactly (IMG_W/2)*(IMG_H/2). oLAST pulses exactly once per frame.
- iRST mid-frame: on the next edge all counters and outputs are at reset values, and the partial frame is lost. The next accepted beat is pixel (0,0).
- iCLR mid-frame: the same counter effect as iRST, without clearing oDATA.
- Line buffer: 1-cycle read latency is allowed. A write (even row) and a read (odd row) never target the same cycle.

## Test plan
- 4x4 frame, CH=1, DW=8, pixels 0..15 raster, iVALID continuous:
  - outputs 5, 7, 13, 15, each 1 cycle after beats 5, 7, 13, 15;
  - oLAST only with 15.
- Signed data, 4x4, CH=1:
  - window {-128,-1,-50,-2} -> -1;
  - window {-128,-128,-128,-128} -> -128;
  - window {127,-128,0,5} -> 127.
- CH=2, 4x4: ch0=i and ch1=15-i for pixel index i.
  - ch0 outputs 5, 7, 13, 15;
  - ch1 outputs 15, 13, 7, 5, in the same beats.
- Gapped input: the 4x4 frame from scenario 1 with random 0-5 idle cycles between beats.
  - The same 4 values are produced, each exactly 1 cycle after its completing beat, with no extra oVALID.
- Two back-to-back 4x4 frames, then iCLR asserted after beat 6 of a third frame, then a full frame:
  - 4+4 outputs, each group closing with oLAST;
  - no output from the cleared partial frame;
  - the post-clear frame yields 4 correct outputs.
- iRST asserted mid-frame, together with iVALID:
  - next cycle oVALID=0, oDATA=0, oLAST=0;
  - a subsequent full frame is pooled correctly from pixel (0,0).
